change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/vm_pkg.sv | 22 ++
 rtl/coin_tube_counter.sv | 23 ++
 rtl/change_dispenser.sv | 142 ++++++++++++++
 tb/tb_change_dispenser.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared vending-machine types and constants: dispenser FSM states and coin values.
package vm_pkg;

    localparam int MONEY_W = 6;

    localparam logic [MONEY_W-1:0] COIN5_VAL  = MONEY_W'(5);
    localparam logic [MONEY_W-1:0] COIN10_VAL = MONEY_W'(10);

    typedef enum logic [2:0] {
        IDLE,
        PLAN,
        EJECT,
        WAIT_ACK,
        FINISH,
        FAULT
    } disp_state_t;

    function automatic logic [MONEY_W-1:0] coin_value(input logic is_10);
        return is_10 ? COIN10_VAL : COIN5_VAL;
    endfunction

endpackage

// File: rtl/coin_tube_counter.sv
// 8-bit saturating up/down coin counter; reset loads the initial tube fill.
module coin_tube_counter #(
    parameter int INIT = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] count
);

    // A simultaneous refill and dispense cancel out, so only one-sided changes move the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 8'(INIT);
        end else if (inc && !dec) begin
            if (count != 8'hFF) count <= count + 8'd1;
        end else if (dec && !inc) begin
            if (count != 8'd0) count <= count - 8'd1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: pays out 10s then 5s, one coin per hopper handshake,
// and parks in FAULT when the exit sensor does not confirm a coin in time.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int INIT_10     = 20,
    parameter int INIT_5      = 20,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               chg_valid,
    input  logic [MONEY_W-1:0] chg_amount,
    output logic               chg_ready,
    input  logic               hopper_ack,
    input  logic               refill_10,
    input  logic               refill_5,
    input  logic               service_clear,
    output logic               eject_10,
    output logic               eject_5,
    output logic               busy,
    output logic               done,
    output logic [MONEY_W-1:0] shortfall,
    output logic               jam,
    output logic [7:0]         inv_10,
    output logic [7:0]         inv_5
);

    localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    // WAIT_ACK starts one cycle after the eject pulse, so the last cycle that may
    // still see an ack is the one where the counter holds ACK_TIMEOUT-2.
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 2);

    disp_state_t        state, state_n;
    logic [MONEY_W-1:0] remaining, remaining_n;
    logic [MONEY_W-1:0] shortfall_n;
    logic [CNT_W-1:0]   ack_cnt, ack_cnt_n;
    logic               coin_is_10, coin_is_10_n;
    logic               fault_new, fault_new_n;
    logic               dec_10, dec_5;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            shortfall  <= '0;
            ack_cnt    <= '0;
            coin_is_10 <= 1'b0;
            fault_new  <= 1'b0;
        end else begin
            state      <= state_n;
            remaining  <= remaining_n;
            shortfall  <= shortfall_n;
            ack_cnt    <= ack_cnt_n;
            coin_is_10 <= coin_is_10_n;
            fault_new  <= fault_new_n;
        end
    end

    // NOTE: every signal gets a default first so no path through the case infers a latch.
    always_comb begin
        state_n      = state;
        remaining_n  = remaining;
        shortfall_n  = shortfall;
        ack_cnt_n    = ack_cnt;
        coin_is_10_n = coin_is_10;
        fault_new_n  = 1'b0;
        dec_10       = 1'b0;
        dec_5        = 1'b0;
        case (state)
            IDLE: begin
                if (chg_valid) begin
                    remaining_n = chg_amount;
                    shortfall_n = '0;
                    state_n     = PLAN;
                end
            end
            PLAN: begin
                if (remaining >= COIN10_VAL && inv_10 != 8'd0) begin
                    coin_is_10_n = 1'b1;
                    state_n      = EJECT;
                end else if (remaining >= COIN5_VAL && inv_5 != 8'd0) begin
                    coin_is_10_n = 1'b0;
                    state_n      = EJECT;
                end else begin
                    state_n = FINISH;
                end
            end
            EJECT: begin
                ack_cnt_n = '0;
                state_n   = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (hopper_ack) begin
                    remaining_n = remaining - coin_value(coin_is_10);
                    dec_10      = coin_is_10;
                    dec_5       = !coin_is_10;
                    state_n     = PLAN;
                end else if (ack_cnt == ACK_LAST) begin
                    shortfall_n = remaining;
                    fault_new_n = 1'b1;
                    state_n     = FAULT;
                end else begin
                    ack_cnt_n = ack_cnt + 1'b1;
                end
            end
            FINISH: begin
                shortfall_n = remaining;
                state_n     = IDLE;
            end
            FAULT: begin
                if (service_clear) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign chg_ready = (state == IDLE);
    assign busy      = (state != IDLE) && (state != FAULT);
    assign jam       = (state == FAULT);
    assign eject_10  = (state == EJECT) && coin_is_10;
    assign eject_5   = (state == EJECT) && !coin_is_10;
    assign done      = (state == FINISH) || fault_new;

    coin_tube_counter #(.INIT(INIT_10)) u_tube_10 (
        .clk   (clk),
        .rst   (rst),
        .inc   (refill_10),
        .dec   (dec_10),
        .count (inv_10)
    );

    coin_tube_counter #(.INIT(INIT_5)) u_tube_5 (
        .clk   (clk),
        .rst   (rst),
        .inc   (refill_5),
        .dec   (dec_5),
        .count (inv_5)
    );

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: a greedy payout model pushes expected
// results per request, which are popped and compared when the DUT pulses done.
module tb_change_dispenser;

    localparam int INIT_10     = 20;
    localparam int INIT_5      = 20;
    localparam int ACK_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       chg_valid;
    logic [5:0] chg_amount;
    logic       chg_ready;
    logic       hopper_ack;
    logic       refill_10;
    logic       refill_5;
    logic       service_clear;
    logic       eject_10;
    logic       eject_5;
    logic       busy;
    logic       done;
    logic [5:0] shortfall;
    logic       jam;
    logic [7:0] inv_10;
    logic [7:0] inv_5;

    always #5 clk = ~clk;

    change_dispenser #(
        .INIT_10     (INIT_10),
        .INIT_5      (INIT_5),
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .chg_valid     (chg_valid),
        .chg_amount    (chg_amount),
        .chg_ready     (chg_ready),
        .hopper_ack    (hopper_ack),
        .refill_10     (refill_10),
        .refill_5      (refill_5),
        .service_clear (service_clear),
        .eject_10      (eject_10),
        .eject_5       (eject_5),
        .busy          (busy),
        .done          (done),
        .shortfall     (shortfall),
        .jam           (jam),
        .inv_10        (inv_10),
        .inv_5         (inv_5)
    );

    typedef struct {
        int n10;
        int n5;
        int short_amt;
        int inv10;
        int inv5;
    } exp_t;

    exp_t sb[$];
    int   m10, m5;
    int   errors = 0;
    int   checks = 0;
    int   obs_n10, obs_n5, obs_done, first_eject, done_at, both_high;
    logic done_jam;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Greedy reference: pushes the expected payout for one request onto the scoreboard.
    task automatic expect_req(input int amt, input bit acked, input bit refill_at_ack);
        exp_t e;
        int   rem;
        int   v;
        rem   = amt;
        e.n10 = 0;
        e.n5  = 0;
        while (1) begin
            if (rem >= 10 && m10 > 0) v = 10;
            else if (rem >= 5 && m5 > 0) v = 5;
            else break;
            if (v == 10) e.n10++;
            else e.n5++;
            if (!acked) break;
            rem -= v;
            if (v == 10) m10--;
            else m5--;
            if (refill_at_ack) m10 = (m10 < 255) ? m10 + 1 : 255;
        end
        e.short_amt = rem;
        e.inv10     = m10;
        e.inv5      = m5;
        sb.push_back(e);
    endtask

    task automatic request(input int amt);
        @(posedge clk); #1;
        chg_valid  = 1'b1;
        chg_amount = 6'(amt);
        @(negedge clk);
        check("chg_ready_at_accept", chg_ready, 1);
        @(posedge clk); #1;
        chg_valid = 1'b0;
    endtask

    // Runs cycles after an accept; k counts cycles since the accept cycle.
    task automatic serve(input bit do_ack, input bit refill_at_ack, input int budget);
        int cd;
        cd          = -1;
        obs_n10     = 0;
        obs_n5      = 0;
        obs_done    = 0;
        first_eject = -1;
        done_at     = -1;
        both_high   = 0;
        done_jam    = 1'b0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (eject_10 && eject_5) both_high++;
            if (eject_10 || eject_5) begin
                if (first_eject < 0) first_eject = k;
                if (do_ack) cd = 3;
            end
            if (eject_10) obs_n10++;
            if (eject_5) obs_n5++;
            if (done) begin
                obs_done++;
                done_at  = k;
                done_jam = jam;
                break;
            end
            @(posedge clk); #1;
            if (cd > 0) begin
                cd--;
                hopper_ack = (cd == 0);
                refill_10  = refill_at_ack && (cd == 0);
            end else begin
                hopper_ack = 1'b0;
                refill_10  = 1'b0;
            end
        end
        hopper_ack = 1'b0;
        refill_10  = 1'b0;
    endtask

    task automatic score(input string tag);
        exp_t e;
        check({tag, "_sb_depth"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_done_count"}, obs_done, 1);
            check({tag, "_eject10_count"}, obs_n10, e.n10);
            check({tag, "_eject5_count"}, obs_n5, e.n5);
            check({tag, "_eject_overlap"}, both_high, 0);
            @(negedge clk);
            check({tag, "_done_low_after"}, done, 0);
            check({tag, "_shortfall"}, shortfall, e.short_amt);
            check({tag, "_inv10"}, inv_10, e.inv10);
            check({tag, "_inv5"}, inv_5, e.inv5);
        end
    endtask

    task automatic refill_pulses(input bit tube10, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (tube10) refill_10 = 1'b1;
            else refill_5 = 1'b1;
            if (tube10) m10 = (m10 < 255) ? m10 + 1 : 255;
            else m5 = (m5 < 255) ? m5 + 1 : 255;
        end
        @(posedge clk); #1;
        refill_10 = 1'b0;
        refill_5  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int late_done;
        rst           = 1'b1;
        chg_valid     = 1'b0;
        chg_amount    = '0;
        hopper_ack    = 1'b0;
        refill_10     = 1'b0;
        refill_5      = 1'b0;
        service_clear = 1'b0;
        m10           = INIT_10;
        m5            = INIT_5;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_chg_ready", chg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_jam", jam, 0);
        check("rst_done", done, 0);
        check("rst_eject10", eject_10, 0);
        check("rst_eject5", eject_5, 0);
        check("rst_shortfall", shortfall, 0);
        check("rst_inv10", inv_10, m10);
        check("rst_inv5", inv_5, m5);

        // Stray ack while idle must not touch the tubes.
        @(posedge clk); #1 hopper_ack = 1'b1;
        @(posedge clk); #1 hopper_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_inv10", inv_10, m10);
        check("idle_ack_inv5", inv_5, m5);

        request(35);
        expect_req(35, 1'b1, 1'b0);
        serve(1'b1, 1'b0, 200);
        check("req35_first_eject_latency", first_eject, 2);
        score("req35");

        request(37);
        expect_req(37, 1'b1, 1'b0);
        serve(1'b1, 1'b0, 200);
        score("req37");

        request(0);
        expect_req(0, 1'b1, 1'b0);
        serve(1'b1, 1'b0, 20);
        check("req0_done_cycle", done_at, 2);
        score("req0");

        request(60);
        expect_req(60, 1'b1, 1'b0);
        serve(1'b1, 1'b0, 200);
        score("req60");

        request(63);
        expect_req(63, 1'b1, 1'b0);
        serve(1'b1, 1'b0, 200);
        score("req63");

        request(10);
        expect_req(10, 1'b1, 1'b0);
        serve(1'b1, 1'b0, 200);
        score("req10");

        // One 10-coin left: request 30 must fall back to 5s.
        check("pre30_inv10", inv_10, 1);
        request(30);
        expect_req(30, 1'b1, 1'b0);
        serve(1'b1, 1'b0, 200);
        score("req30_low10");

        refill_pulses(1'b1, 3);
        @(negedge clk);
        check("refill3_inv10", inv_10, m10);

        // Refill of the 10 tube lands in the same cycle as the ack of a 10-coin.
        request(10);
        expect_req(10, 1'b1, 1'b1);
        serve(1'b1, 1'b1, 200);
        score("req10_refill_at_ack");

        refill_pulses(1'b1, 260);
        @(negedge clk);
        check("refill_sat_inv10", inv_10, 255);
        refill_pulses(1'b0, 2);
        @(negedge clk);
        check("refill5_inv5", inv_5, m5);

        request(10);
        expect_req(10, 1'b0, 1'b0);
        serve(1'b0, 1'b0, 60);
        check("timeout_jam_delay", done_at - first_eject, ACK_TIMEOUT);
        check("timeout_jam_with_done", done_jam, 1);
        score("timeout");
        check("fault_jam", jam, 1);
        check("fault_busy", busy, 0);
        check("fault_chg_ready", chg_ready, 0);

        @(posedge clk); #1 hopper_ack = 1'b1;
        @(posedge clk); #1 hopper_ack = 1'b0;
        @(negedge clk);
        check("fault_ack_inv10", inv_10, m10);
        check("fault_eject10", eject_10, 0);

        @(posedge clk); #1 service_clear = 1'b1;
        @(posedge clk); #1 service_clear = 1'b0;
        @(negedge clk);
        check("clear_chg_ready", chg_ready, 1);
        check("clear_jam", jam, 0);

        // Reset while waiting for an ack abandons the request silently.
        request(10);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (eject_10 || eject_5) begin
                seen = 1;
                break;
            end
        end
        check("rst_mid_eject_seen", seen, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m10 = INIT_10;
        m5  = INIT_5;
        @(negedge clk);
        check("rst_mid_chg_ready", chg_ready, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_inv10", inv_10, m10);
        check("rst_mid_inv5", inv_5, m5);
        late_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done) late_done++;
        end
        check("rst_mid_no_done", late_done, 0);
        check("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
